riscv_cache_tag_queue: RTL and testbench

RISCV_CACHE_TAG_QUEUE -- requirements
Module: riscv_cache_tag_queue

---
 rtl/biu_constants_pkg.sv | 14 +
 rtl/riscv_cache_pkg.sv | 46 ++++
 rtl/riscv_cache_tag_queue_if.sv | 35 +++
 rtl/riscv_cache_tag_fifo.sv | 60 ++++++
 rtl/riscv_cache_tag_queue.sv | 134 +++++++++++++
 tb/tb_riscv_cache_tag_queue.sv | 318 +++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/biu_constants_pkg.sv
// Bus interface unit shared types: transfer size and protection attributes.
package biu_constants_pkg;

    typedef enum logic [2:0] {
        BYTE  = 3'd0,
        HWORD = 3'd1,
        WORD  = 3'd2,
        DWORD = 3'd3,
        QWORD = 3'd4
    } biu_size_t;

    typedef logic [2:0] biu_prot_t;

endpackage

// File: rtl/riscv_cache_pkg.sv
// Cache geometry helpers plus byte-enable and alignment decode for the tag queue.
package riscv_cache_pkg;
    import biu_constants_pkg::*;

    // SIZE is in KiB, block_size in bits.
    function automatic int unsigned no_of_sets(int unsigned size, int unsigned block_size,
                                               int unsigned ways);
        return (8 * size * 1024) / (block_size * ways);
    endfunction

    function automatic int unsigned no_of_block_offset_bits(int unsigned block_size);
        return $clog2(block_size / 8);
    endfunction

    function automatic int unsigned no_of_index_bits(int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned no_of_tag_bits(int unsigned plen, int unsigned idx_bits,
                                                   int unsigned blk_offs_bits);
        return plen - idx_bits - blk_offs_bits;
    endfunction

    // Unshifted byte-enable mask; a DWORD on a 32-bit bus is clipped to one word.
    function automatic logic [7:0] size2be(biu_size_t size, int unsigned xlen);
        case (size)
            BYTE:    return 8'h01;
            HWORD:   return 8'h03;
            WORD:    return 8'h0f;
            DWORD:   return (xlen == 64) ? 8'hff : 8'h0f;
            default: return 8'h00;
        endcase
    endfunction

    // Address not a multiple of the access size, or size wider than the bus.
    function automatic logic is_misaligned(biu_size_t size, logic [2:0] adr, int unsigned xlen);
        case (size)
            BYTE:    return 1'b0;
            HWORD:   return adr[0];
            WORD:    return |adr[1:0];
            DWORD:   return (xlen == 32) ? 1'b1 : |adr;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/riscv_cache_tag_queue_if.sv
// Downstream side of the tag queue: head-entry payload plus valid/ready handshake.
interface riscv_cache_tag_queue_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned PLEN = XLEN
);
    import biu_constants_pkg::*;

    logic              req_o;
    logic              ready_i;
    logic              wreq_o;
    logic [PLEN-1:0]   adr_o;
    biu_size_t         size_o;
    logic              lock_o;
    biu_prot_t         prot_o;
    logic              we_o;
    logic [XLEN-1:0]   q_o;
    logic [XLEN/8-1:0] be_o;
    logic              misaligned_o;
    logic              invalidate_o;
    logic              clean_o;
    logic              pagefault_o;

    modport master (
        output req_o, wreq_o, adr_o, size_o, lock_o, prot_o, we_o, q_o, be_o,
               misaligned_o, invalidate_o, clean_o, pagefault_o,
        input  ready_i
    );

    modport slave (
        input  req_o, wreq_o, adr_o, size_o, lock_o, prot_o, we_o, q_o, be_o,
               misaligned_o, invalidate_o, clean_o, pagefault_o,
        output ready_i
    );

endinterface

// File: rtl/riscv_cache_tag_fifo.sv
// FWFT storage with pointers, occupancy and a per-entry clearable flag bit.
module riscv_cache_tag_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           d,
    input  logic                       flag_d,
    input  logic                       flag_clr,
    output logic [WIDTH-1:0]           q,
    output logic                       flag_q,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [DEPTH-1:0] flags;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Flag bits are cleared en masse; a same-cycle push cannot escape the clear.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            flags <= '0;
        end else begin
            if (flag_clr) flags <= '0;
            if (push)     flags[wptr] <= flag_d & ~flag_clr;
        end
    end

    // Payload storage is left unreset; the top masks it while empty.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) mem[wptr] <= d;
    end

    assign q      = mem[rptr];
    assign flag_q = flags[rptr];

endmodule

// File: rtl/riscv_cache_tag_queue.sv
// Request queue between the cache core and its tag stage; decodes be/misalignment at push.
module riscv_cache_tag_queue
    import biu_constants_pkg::*;
    import riscv_cache_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned PLEN       = XLEN,
    parameter int unsigned SIZE       = 64,
    parameter int unsigned BLOCK_SIZE = XLEN,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned DEPTH      = 2,
    localparam int unsigned SETS          = no_of_sets(SIZE, BLOCK_SIZE, WAYS),
    localparam int unsigned BLK_OFFS_BITS = no_of_block_offset_bits(BLOCK_SIZE),
    localparam int unsigned IDX_BITS      = no_of_index_bits(SETS),
    localparam int unsigned TAG_BITS      = no_of_tag_bits(PLEN, IDX_BITS, BLK_OFFS_BITS)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       req_i,
    output logic                       ready_o,
    input  logic [PLEN-1:0]            phys_adr_i,
    input  biu_size_t                  size_i,
    input  logic                       lock_i,
    input  biu_prot_t                  prot_i,
    input  logic                       we_i,
    input  logic [XLEN-1:0]            d_i,
    input  logic                       invalidate_i,
    input  logic                       clean_i,
    input  logic                       pagefault_i,
    input  logic                       invalidate_all_blocks_i,
    output logic [TAG_BITS-1:0]        core_tag_o,
    output logic [IDX_BITS-1:0]        idx_o,
    riscv_cache_tag_queue_if.master    bus,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int unsigned BE_W    = XLEN / 8;
    localparam int unsigned ADR_LSB = $clog2(BE_W);
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PLEN-1:0] adr;
        biu_size_t       size;
        logic            lock;
        biu_prot_t       prot;
        logic            we;
        logic [XLEN-1:0] d;
        logic [BE_W-1:0] be;
        logic            misaligned;
        logic            clean;
        logic            pagefault;
    } entry_t;

    entry_t                push_entry;
    entry_t                head;
    logic [$bits(entry_t)-1:0] head_bits;
    logic                  head_inv;
    logic [CNT_W-1:0]      count;
    logic                  req;
    logic                  push;
    logic                  pop;
    logic                  misaligned;
    logic [BE_W-1:0]       be;

    assign core_tag_o = phys_adr_i[PLEN-1 -: TAG_BITS];
    assign idx_o      = phys_adr_i[BLK_OFFS_BITS +: IDX_BITS];

    assign req     = (count != '0);
    assign ready_o = (count < CNT_W'(DEPTH));
    assign count_o = count;
    assign push    = req_i & ready_o & ~flush_i;
    assign pop     = req & bus.ready_i & ~flush_i;

    // Byte enables and alignment decoded once, at push time.
    always_comb begin
        misaligned = is_misaligned(size_i, phys_adr_i[2:0], XLEN);
        be         = BE_W'(size2be(size_i, XLEN));
        if (!(size_i == DWORD && XLEN == 32)) begin
            be = misaligned ? '0 : be << phys_adr_i[ADR_LSB-1:0];
        end
    end

    // Pack the incoming request into a storage entry.
    always_comb begin
        push_entry            = '0;
        push_entry.adr        = phys_adr_i;
        push_entry.size       = size_i;
        push_entry.lock       = lock_i;
        push_entry.prot       = prot_i;
        push_entry.we         = we_i;
        push_entry.d          = d_i;
        push_entry.be         = be;
        push_entry.misaligned = misaligned;
        push_entry.clean      = clean_i;
        push_entry.pagefault  = pagefault_i;
    end

    riscv_cache_tag_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk_i),
        .rst      (rst_i),
        .flush    (flush_i),
        .push     (push),
        .pop      (pop),
        .d        (push_entry),
        .flag_d   (invalidate_i),
        .flag_clr (invalidate_all_blocks_i),
        .q        (head_bits),
        .flag_q   (head_inv),
        .count    (count)
    );

    assign head = entry_t'(head_bits);

    // Present the head entry, forced to zero while the queue is empty.
    always_comb begin
        bus.req_o        = req;
        bus.wreq_o       = req & head.we;
        bus.adr_o        = req ? head.adr : '0;
        bus.size_o       = req ? head.size : BYTE;
        bus.lock_o       = req & head.lock;
        bus.prot_o       = req ? head.prot : '0;
        bus.we_o         = req & head.we;
        bus.q_o          = req ? head.d : '0;
        bus.be_o         = req ? head.be : '0;
        bus.misaligned_o = req & head.misaligned;
        bus.invalidate_o = req & head_inv;
        bus.clean_o      = req & head.clean;
        bus.pagefault_o  = req & head.pagefault;
    end

endmodule

// File: tb/tb_riscv_cache_tag_queue.sv
// Bench for riscv_cache_tag_queue: directed scenarios plus random traffic against a queue model.
module tb_riscv_cache_tag_queue;
    import biu_constants_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst, flush, req, lock, we, inv, clean, pf, inv_all, rdy;
    biu_size_t   size;
    biu_prot_t   prot;
    logic [63:0] adr, d;

    logic        ready64, ready32;
    logic [1:0]  count64, count32;
    logic [48:0] tag64;
    logic [11:0] idx64;
    logic [16:0] tag32;
    logic [12:0] idx32;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] adr;
        biu_size_t   size;
        logic        lock;
        biu_prot_t   prot;
        logic        we;
        logic [63:0] d;
        logic        inv;
        logic        clean;
        logic        pf;
    } ent_t;

    ent_t mq[$];

    riscv_cache_tag_queue_if #(.XLEN(64), .PLEN(64)) bus64 ();
    riscv_cache_tag_queue_if #(.XLEN(32), .PLEN(32)) bus32 ();

    assign bus64.ready_i = rdy;
    assign bus32.ready_i = rdy;

    riscv_cache_tag_queue #(.XLEN(64), .DEPTH(DEPTH)) u_dut64 (
        .clk_i (clk), .rst_i (rst), .flush_i (flush), .req_i (req), .ready_o (ready64),
        .phys_adr_i (adr), .size_i (size), .lock_i (lock), .prot_i (prot), .we_i (we),
        .d_i (d), .invalidate_i (inv), .clean_i (clean), .pagefault_i (pf),
        .invalidate_all_blocks_i (inv_all), .core_tag_o (tag64), .idx_o (idx64),
        .bus (bus64), .count_o (count64)
    );

    riscv_cache_tag_queue #(.XLEN(32), .DEPTH(DEPTH)) u_dut32 (
        .clk_i (clk), .rst_i (rst), .flush_i (flush), .req_i (req), .ready_o (ready32),
        .phys_adr_i (adr[31:0]), .size_i (size), .lock_i (lock), .prot_i (prot), .we_i (we),
        .d_i (d[31:0]), .invalidate_i (inv), .clean_i (clean), .pagefault_i (pf),
        .invalidate_all_blocks_i (inv_all), .core_tag_o (tag32), .idx_o (idx32),
        .bus (bus32), .count_o (count32)
    );

    always #5 clk = ~clk;

    // Spec-level byte enables for a 64-bit bus.
    function automatic logic [7:0] exp_be(ent_t e);
        int unsigned nb, off;
        if (e.size > DWORD) return 8'h00;
        nb  = 1 << int'(e.size);
        off = int'(e.adr[2:0]);
        if (off % nb != 0) return 8'h00;
        return 8'(((1 << nb) - 1) << off);
    endfunction

    function automatic logic exp_mis(ent_t e);
        if (e.size > DWORD) return 1'b1;
        return (int'(e.adr[2:0]) % (1 << int'(e.size))) != 0;
    endfunction

    task automatic idle();
        rst = 0; flush = 0; req = 0; rdy = 0; inv_all = 0;
        lock = 0; we = 0; inv = 0; clean = 0; pf = 0;
        size = BYTE; prot = '0; adr = '0; d = '0;
    endtask

    // Advance one clock and apply the same handshake rules to the model queue.
    task automatic tick();
        bit   do_pop, do_push;
        ent_t e;
        do_pop  = (mq.size() != 0) && rdy;
        do_push = req && (mq.size() < DEPTH);
        @(posedge clk);
        #1;
        if (rst || flush) begin
            mq.delete();
        end else begin
            if (inv_all) foreach (mq[i]) mq[i].inv = 1'b0;
            if (do_pop) e = mq.pop_front();
            if (do_push) begin
                e = '{adr: adr, size: size, lock: lock, prot: prot, we: we, d: d,
                      inv: inv & ~inv_all, clean: clean, pf: pf};
                mq.push_back(e);
            end
        end
    endtask

    task automatic test_reset();
        idle();
        rst = 1; req = 1; rdy = 1;
        tick();
        tick();
        checks++; if (count64 !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count64); end
        checks++; if (ready64 !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready64); end
        idle();
        tick();
        checks++;
        if ({bus64.req_o, bus64.wreq_o, bus64.be_o, bus64.adr_o, bus64.invalidate_o} !== '0) begin
            errors++; $display("FAIL reset_outputs req %b wreq %b be %h adr %h exp all 0",
                               bus64.req_o, bus64.wreq_o, bus64.be_o, bus64.adr_o);
        end
        checks++; if (ready64 !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %b exp 1", ready64); end
    endtask

    task automatic test_word_write();
        idle();
        req = 1; adr = 64'h1004; size = WORD; we = 1; d = {$urandom, $urandom};
        tick();
        req = 0;
        checks++;
        if ({bus64.req_o, bus64.wreq_o, bus64.be_o} !== {1'b1, 1'b1, 8'hf0}) begin
            errors++; $display("FAIL word_write req %b wreq %b be %h exp 1 1 f0",
                               bus64.req_o, bus64.wreq_o, bus64.be_o);
        end
        checks++; if (bus64.q_o !== d) begin errors++; $display("FAIL word_write_data got %h exp %h", bus64.q_o, d); end
        rdy = 1;
        tick();
        checks++; if (bus64.req_o !== 1'b0) begin errors++; $display("FAIL word_drain got %b exp 0", bus64.req_o); end
    endtask

    task automatic test_full();
        idle();
        req = 1;
        for (int i = 0; i < 3; i++) begin
            adr = 64'(i * 8);
            tick();
            checks++;
            if (ready64 !== (i == 0)) begin
                errors++; $display("FAIL full_ready push %0d got %b exp %b", i, ready64, i == 0);
            end
        end
        checks++; if (count64 !== 2'd2) begin errors++; $display("FAIL full_count got %0d exp 2", count64); end
        checks++; if (bus64.adr_o !== 64'h0) begin errors++; $display("FAIL full_head got %h exp 0", bus64.adr_o); end
        rdy = 1; adr = 64'h40;
        tick();
        checks++;
        if ({count64, ready64} !== {2'd1, 1'b1}) begin
            errors++; $display("FAIL full_pop count %0d ready %b exp 1 1", count64, ready64);
        end
        checks++; if (bus64.adr_o !== 64'h8) begin errors++; $display("FAIL full_pop_head got %h exp 8", bus64.adr_o); end
        req = 0;
        tick();
        checks++; if (count64 !== 2'd0) begin errors++; $display("FAIL full_drain got %0d exp 0", count64); end
    endtask

    task automatic test_misaligned();
        idle();
        req = 1; adr = 64'h3; size = HWORD;
        tick();
        req = 0;
        checks++;
        if ({bus64.misaligned_o, bus64.be_o} !== {1'b1, 8'h00}) begin
            errors++; $display("FAIL hword_mis64 mis %b be %h exp 1 00", bus64.misaligned_o, bus64.be_o);
        end
        checks++;
        if ({bus32.misaligned_o, bus32.be_o} !== {1'b1, 4'h0}) begin
            errors++; $display("FAIL hword_mis32 mis %b be %h exp 1 0", bus32.misaligned_o, bus32.be_o);
        end
        rdy = 1;
        tick();
        rdy = 0; req = 1; adr = 64'h8; size = DWORD;
        tick();
        req = 0;
        checks++;
        if ({bus64.misaligned_o, bus64.be_o} !== {1'b0, 8'hff}) begin
            errors++; $display("FAIL dword64 mis %b be %h exp 0 ff", bus64.misaligned_o, bus64.be_o);
        end
        checks++;
        if ({bus32.misaligned_o, bus32.be_o} !== {1'b1, 4'hf}) begin
            errors++; $display("FAIL dword32 mis %b be %h exp 1 f", bus32.misaligned_o, bus32.be_o);
        end
        checks++; if (idx32 !== adr[14:2]) begin errors++; $display("FAIL idx32 got %h exp %h", idx32, adr[14:2]); end
        rdy = 1;
        tick();
    endtask

    task automatic test_invalidate_all();
        idle();
        req = 1; inv = 1;
        tick();
        tick();
        req = 0; inv = 0;
        checks++; if (bus64.invalidate_o !== 1'b1) begin errors++; $display("FAIL inv_head got %b exp 1", bus64.invalidate_o); end
        inv_all = 1;
        tick();
        inv_all = 0;
        checks++;
        if ({count64, bus64.invalidate_o} !== {2'd2, 1'b0}) begin
            errors++; $display("FAIL inv_all count %0d inv %b exp 2 0", count64, bus64.invalidate_o);
        end
        rdy = 1;
        tick();
        checks++;
        if ({count64, bus64.invalidate_o} !== {2'd1, 1'b0}) begin
            errors++; $display("FAIL inv_second count %0d inv %b exp 1 0", count64, bus64.invalidate_o);
        end
        tick();
        rdy = 0; req = 1; inv = 1; inv_all = 1;
        tick();
        idle();
        checks++;
        if ({bus64.req_o, bus64.invalidate_o} !== {1'b1, 1'b0}) begin
            errors++; $display("FAIL inv_same_cycle req %b inv %b exp 1 0", bus64.req_o, bus64.invalidate_o);
        end
        rdy = 1;
        tick();
    endtask

    task automatic test_flush();
        idle();
        req = 1; we = 1; lock = 1; clean = 1; pf = 1; prot = 3'h5; adr = 64'h1238; d = 64'hdead_beef;
        tick();
        flush = 1;
        tick();
        flush = 0; req = 0;
        checks++;
        if ({bus64.req_o, bus64.wreq_o, bus64.adr_o, bus64.lock_o, bus64.prot_o, bus64.q_o,
             bus64.be_o, bus64.clean_o, bus64.pagefault_o, count64} !== '0) begin
            errors++; $display("FAIL flush_outputs req %b adr %h q %h be %h count %0d exp all 0",
                               bus64.req_o, bus64.adr_o, bus64.q_o, bus64.be_o, count64);
        end
        checks++; if (ready64 !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", ready64); end
        tick();
        checks++; if (count64 !== 2'd0) begin errors++; $display("FAIL flush_dropped got %0d exp 0", count64); end
    endtask

    task automatic test_mid_reset();
        idle();
        req = 1;
        tick();
        tick();
        rst = 1; rdy = 1;
        tick();
        idle();
        checks++;
        if ({bus64.req_o, count64, ready64} !== {1'b0, 2'd0, 1'b1}) begin
            errors++; $display("FAIL mid_reset req %b count %0d ready %b exp 0 0 1",
                               bus64.req_o, count64, ready64);
        end
    endtask

    task automatic test_random();
        ent_t         h;
        logic [149:0] got, exp;
        for (int c = 0; c < 400; c++) begin
            rst     = ($urandom % 64) == 0;
            flush   = ($urandom % 16) == 0;
            inv_all = ($urandom % 8) == 0;
            req     = ($urandom % 4) != 0;
            rdy     = ($urandom % 2) != 0;
            adr     = {$urandom, $urandom};
            size    = biu_size_t'(3'($urandom_range(0, 4)));
            lock    = 1'($urandom); we = 1'($urandom); inv = 1'($urandom);
            clean   = 1'($urandom); pf = 1'($urandom); prot = 3'($urandom);
            d       = {$urandom, $urandom};
            tick();
            checks++;
            if (count64 !== 2'(mq.size())) begin
                errors++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", c, count64, mq.size());
            end
            checks++;
            if (ready64 !== 1'(mq.size() < DEPTH)) begin
                errors++; $display("FAIL rnd_ready cyc %0d got %b", c, ready64);
            end
            checks++;
            if ({tag64, idx64} !== adr[63:3]) begin
                errors++; $display("FAIL rnd_tag_idx cyc %0d got %h/%h adr %h", c, tag64, idx64, adr);
            end
            got = {bus64.req_o, bus64.wreq_o, bus64.adr_o, bus64.size_o, bus64.lock_o, bus64.prot_o,
                   bus64.we_o, bus64.q_o, bus64.be_o, bus64.misaligned_o, bus64.invalidate_o,
                   bus64.clean_o, bus64.pagefault_o};
            exp = '0;
            if (mq.size() != 0) begin
                h   = mq[0];
                exp = {1'b1, h.we, h.adr, h.size, h.lock, h.prot, h.we, h.d, exp_be(h), exp_mis(h),
                       h.inv, h.clean, h.pf};
            end
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL rnd_head cyc %0d got %h exp %h", c, got, exp);
            end
        end
        idle();
        flush = 1;
        tick();
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_word_write();
        test_full();
        test_misaligned();
        test_invalidate_all();
        test_flush();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
